// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the multi-lane serial parity generator/checker.
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_e;

    // Bit-counter width needed to count data beats 0..FRAME_LEN-1.
    function automatic int cnt_w(input int frame_len);
        return $clog2(frame_len);
    endfunction

    // Parity of accumulated data, incoming bit and mode: transmit bit or mismatch flag.
    function automatic logic par_bit(input logic acc, input logic d, input logic mode);
        return acc ^ d ^ mode;
    endfunction

endpackage

// File: rtl/parity_frame_checker_lane.sv
// One lane: XOR accumulator plus registered generated-parity and error bits.
module parity_lane
    import parity_frame_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic upd,
    input  logic gen_en,
    input  logic chk_en,
    input  logic d_in,
    input  logic mode,
    output logic p_gen,
    output logic err
);

    logic acc_r;
    logic p_gen_r;
    logic err_r;
    logic par_s;

    assign par_s = par_bit(acc_r, d_in, mode);

    // Accumulator: load on frame start, fold in data beats, otherwise hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_r <= 1'b0;
        end else if (load) begin
            acc_r <= d_in;
        end else if (upd) begin
            acc_r <= acc_r ^ d_in;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Generated parity and check result; each holds until its next strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_gen_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            p_gen_r <= gen_en ? par_s : p_gen_r;
            err_r   <= chk_en ? par_s : err_r;
        end
    end

    assign p_gen = p_gen_r;
    assign err   = err_r;

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-lane framed parity generator/checker with shared framing FSM.
// Optional saturating error counter enabled by macro PARITY_ERR_CNT_EN.
module parity_frame_checker
    import parity_frame_pkg::*;
#(
    parameter int LANES     = 1,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [LANES-1:0] d_in,
    input  logic             d_valid,
    input  logic             sof,
    input  logic             mode_odd,
    output logic [LANES-1:0] p_gen,
    output logic             p_gen_vld,
    output logic [LANES-1:0] err,
    output logic             err_vld,
    output logic             busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int            CW   = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_e        state_r;
    logic [CW-1:0] cnt_r;
    logic          mode_r;
    logic          busy_r;
    logic          p_gen_vld_r;
    logic          err_vld_r;

    logic start_s;
    logic upd_s;
    logic last_s;
    logic chk_s;

    // Beat decode: a qualified sof always wins and restarts the frame.
    always_comb begin
        start_s = 1'b0;
        upd_s   = 1'b0;
        last_s  = 1'b0;
        chk_s   = 1'b0;
        if (d_valid && sof) begin
            start_s = 1'b1;
        end else if (d_valid && (state_r == DATA)) begin
            upd_s  = 1'b1;
            last_s = (cnt_r == LAST);
        end else if (d_valid && (state_r == PAR)) begin
            chk_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Framing FSM with bit counter, mode latch and registered pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            mode_r      <= 1'b0;
            busy_r      <= 1'b0;
            p_gen_vld_r <= 1'b0;
            err_vld_r   <= 1'b0;
        end else begin
            p_gen_vld_r <= last_s;
            err_vld_r   <= chk_s;
            if (start_s) begin
                state_r <= DATA;
                cnt_r   <= CW'(1);
                mode_r  <= mode_odd;
                busy_r  <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    DATA: begin
                        if (last_s) begin
                            state_r <= PAR;
                            cnt_r   <= '0;
                        end else if (upd_s) begin
                            cnt_r <= cnt_r + CW'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                    PAR: begin
                        if (chk_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= PAR;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        parity_lane u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .load   (start_s),
            .upd    (upd_s),
            .gen_en (last_s),
            .chk_en (chk_s),
            .d_in   (d_in[i]),
            .mode   (mode_r),
            .p_gen  (p_gen[i]),
            .err    (err[i])
        );
    end

    assign p_gen_vld = p_gen_vld_r;
    assign err_vld   = err_vld_r;
    assign busy      = busy_r;

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Counts frames with any failing lane, one cycle after the err_vld pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_r <= '0;
        end else if (err_vld_r && (|err) && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + CNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    // Without the counter, err/err_vld are the only error reporting.
`endif

endmodule
